divu_32bits: RTL and testbench

DIVU_32BITS -- requirements
Module: divu_32bits

---
 rtl/divu_32bits_pkg.sv | 14 +
 rtl/divu_32bits_sub.sv | 15 +
 rtl/divu_32bits.sv | 111 +++++++++++
 tb/tb_divu_32bits.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/divu_32bits_pkg.sv
// Shared constants and state encoding for the 32-bit unsigned restoring divider.
package divu_32bits_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divu_32bits_sub.sv
// 33-bit trial subtractor: diff = a - b, borrow set when b > a.
module sub_33bits (
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic [32:0] diff,
    output logic        borrow
);

    logic [33:0] full;

    assign full   = {1'b0, a} - {1'b0, b};
    assign diff   = full[32:0];
    assign borrow = full[33];

endmodule

// File: rtl/divu_32bits.sv
// Restoring shift-subtract unsigned divider, one quotient bit per CALC cycle.
// state | meaning: IDLE waiting for start | CALC 32 shift-subtract steps | DONE results valid, done pulse
module divu_32bits
    import divu_32bits_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_work, quo_work, div_reg;
    logic             zero_pend;
    logic             accept, last, div_nz;
    logic [WIDTH:0]   trial_a, trial_b, trial_diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic             unused_msb;

    assign div_nz = (divisor != '0);
    // A zero-divisor request spends one IDLE cycle pending before DONE; no new start meanwhile.
    assign accept = start && !zero_pend && (state == IDLE || state == DONE);
    assign last   = (cnt == CNT_LAST);

    assign trial_a = {rem_work, quo_work[WIDTH-1]};
    assign trial_b = {1'b0, div_reg};

    sub_33bits u_sub (
        .a      (trial_a),
        .b      (trial_b),
        .diff   (trial_diff),
        .borrow (borrow)
    );

    // Remainder stays below the divisor, so the kept difference always fits in WIDTH bits.
    assign rem_next   = borrow ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
    assign quo_next   = {quo_work[WIDTH-2:0], ~borrow};
    assign unused_msb = trial_diff[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (zero_pend)             state_next = DONE;
                else if (accept && div_nz) state_next = CALC;
            end
            CALC: if (last) state_next = DONE;
            DONE: state_next = (accept && div_nz) ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            CALC:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rem_work  <= '0;
            quo_work  <= '0;
            div_reg   <= '0;
            zero_pend <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            cnt       <= '0;
            rem_work  <= '0;
            quo_work  <= dividend;
            div_reg   <= divisor;
            zero_pend <= !div_nz;
            if (div_nz) div_zero <= 1'b0;
        end else if (state == CALC) begin
            cnt      <= cnt + 5'd1;
            rem_work <= rem_next;
            quo_work <= quo_next;
            if (last) begin
                quotient  <= quo_next;
                remainder <= rem_next;
            end
        end else if (zero_pend) begin
            zero_pend <= 1'b0;
            quotient  <= '1;
            remainder <= quo_work;
            div_zero  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_divu_32bits.sv
// Directed self-checking bench for divu_32bits with hand-computed expectations.
module tb_divu_32bits;
    import divu_32bits_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst, start;
    logic [DIV_WIDTH-1:0] dividend, divisor;
    logic                 busy, done, div_zero;
    logic [DIV_WIDTH-1:0] quotient, remainder;
    int                   n_cmp = 0;
    int                   n_err = 0;
    int                   done_seen;

    always #5 clk = ~clk;

    divu_32bits #(.WIDTH(DIV_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Called just after the accepting edge; ends just after the done edge (accept + 32).
    task automatic finish_calc(input string tag, input logic [31:0] pq, input logic [31:0] pr,
                               input logic [31:0] eq, input logic [31:0] er);
        chk({tag, " busy_at_accept"}, 32'(busy), 32'd1);
        for (int i = 1; i < 32; i++) begin
            step();
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " done_early"}, 32'(done), 32'd0);
            chk({tag, " q_hold"}, quotient, pq);
            chk({tag, " r_hold"}, remainder, pr);
        end
        step();
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_zero"}, 32'(div_zero), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        step();
        step();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst quotient", quotient, 32'd0);
        chk("rst remainder", remainder, 32'd0);
        chk("rst div_zero", 32'(div_zero), 32'd0);
        rst = 1'b0;

        launch(32'd100, 32'd7);
        finish_calc("100/7", 32'd0, 32'd0, 32'd14, 32'd2);
        step();
        chk("100/7 pulse_end", 32'(done), 32'd0);
        chk("100/7 q_held", quotient, 32'd14);
        chk("100/7 r_held", remainder, 32'd2);

        launch(32'hFFFF_FFFF, 32'd1);
        finish_calc("max/1", 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd0);
        step();

        launch(32'd5, 32'd9);
        finish_calc("5/9", 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd5);
        step();

        launch(32'd1234, 32'd0);
        chk("dz busy_at_accept", 32'(busy), 32'd0);
        chk("dz done_at_accept", 32'(done), 32'd0);
        step();
        chk("dz done", 32'(done), 32'd1);
        chk("dz busy", 32'(busy), 32'd0);
        chk("dz quotient", quotient, 32'hFFFF_FFFF);
        chk("dz remainder", remainder, 32'd1234);
        chk("dz div_zero", 32'(div_zero), 32'd1);
        step();
        chk("dz pulse_end", 32'(done), 32'd0);
        chk("dz div_zero_held", 32'(div_zero), 32'd1);
        chk("dz remainder_held", remainder, 32'd1234);

        // 50/5 with a 99/3 request arriving mid-CALC, which must be dropped.
        launch(32'd50, 32'd5);
        for (int i = 1; i < 10; i++) step();
        dividend = 32'd99;
        divisor  = 32'd3;
        start    = 1'b1;
        step();
        start    = 1'b0;
        chk("mid busy", 32'(busy), 32'd1);
        chk("mid q_hold", quotient, 32'hFFFF_FFFF);
        for (int i = 11; i < 32; i++) step();
        step();
        chk("50/5 done", 32'(done), 32'd1);
        chk("50/5 quotient", quotient, 32'd10);
        chk("50/5 remainder", remainder, 32'd0);
        chk("50/5 div_zero_cleared", 32'(div_zero), 32'd0);
        step();
        chk("50/5 idle busy", 32'(busy), 32'd0);
        chk("50/5 q_held", quotient, 32'd10);
        chk("50/5 r_held", remainder, 32'd0);

        // Abort a CALC with reset; start during reset must be ignored.
        launch(32'd1000, 32'd3);
        for (int i = 1; i < 15; i++) step();
        chk("abort pre busy", 32'(busy), 32'd1);
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 32'd999;
        divisor  = 32'd1;
        step();
        rst      = 1'b0;
        start    = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort quotient", quotient, 32'd0);
        chk("abort remainder", remainder, 32'd0);
        chk("abort div_zero", 32'(div_zero), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) done_seen++;
        end
        chk("abort no_activity", 32'(done_seen), 32'd0);

        launch(32'd81, 32'd9);
        finish_calc("81/9", 32'd0, 32'd0, 32'd9, 32'd0);
        step();

        // Start held high through DONE: second operation accepted right at DONE.
        dividend = 32'd17;
        divisor  = 32'd4;
        start    = 1'b1;
        step();
        finish_calc("17/4 a", 32'd9, 32'd0, 32'd4, 32'd1);
        step();
        start = 1'b0;
        chk("b2b done_dropped", 32'(done), 32'd0);
        finish_calc("17/4 b", 32'd4, 32'd1, 32'd4, 32'd1);
        step();
        chk("b2b idle", 32'(busy), 32'd0);
        chk("b2b pulse_end", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
